// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter/sequencer sharing one combinational ALU between two
//   requesters. A granted request is latched, driven into the ALU for one
//   cycle, and the registered result/zero flag is held on the response
//   channel of the granted requester until that requester accepts it.
//
// Handshake semantics (both request and response channels): a transfer
// happens at a rising edge where valid and ready are both high. A source
// keeps valid and payload stable until the transfer. Ready may depend
// combinationally on valid (request side), never the other way round.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester request channel (bit i = req i)
//   req_a0/b0/op0           requester 0 operands and ALU control
//   req_a1/b1/op1           requester 1 operands and ALU control
//   rsp_valid/rsp_ready     per-requester response channel
//   rsp_result/rsp_zflag    registered ALU result/zero flag (shared)
//   alu_a/alu_b/alu_control to external ALU, straight from operand regs
//   alu_result/alu_zflag    from external ALU
//   busy                    high whenever the FSM is not IDLE
//   dbg_state               current FSM state (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 5,
  parameter int OP_W   = 2,
  parameter int RES_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_zflag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_zflag,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              zf_q, zf_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              sel;

  // Arbitration: a lone requester wins; on contention the one that did not
  // win last time wins, so continuous contention alternates strictly.
  always_comb begin
    sel = 1'b0;
    case (req_valid)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant_q;
      default: sel = 1'b0;
    endcase
  end

  // Ready is offered only in IDLE, only to the selected requester, and is
  // forced low while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready = sel ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    zf_d         = zf_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if ((req_valid & req_ready) != 2'b00) begin
          grant_d = sel;
          a_d     = sel ? req_a1  : req_a0;
          b_d     = sel ? req_b1  : req_b0;
          op_d    = sel ? req_op1 : req_op0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = alu_result;
        zf_d        = alu_zflag;
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        // Only the granted requester's rsp_ready completes the response.
        if (rsp_ready[grant_q]) begin
          rsp_valid_d  = 2'b00;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
      zf_q         <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
      zf_q         <= zf_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // ALU inputs come only from registers: no req_* to alu_* timing path.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = res_q;
  assign rsp_zflag   = zf_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule
